uart_rx: RTL
============

# uart_rx

UART receiver: samples the serial line at 16× the bit rate and detects the start bit. It deserializes WIDTH data bits LSB-first, then checks the stop bit and, optionally, parity. It is the receive-side counterpart of the transmitter's shift-out path and consumes the same 16× tick from the shared baud generator. It delivers each byte with a one-cycle valid strobe to the downstream consumer.

## Interface
- WIDTH, 8: data bits per frame.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Used only when parity is compiled in.
- clk  input  1  system clock.
- rst  input  1  reset: asynchronous, active-low.
- tick_16x  input  1  one-clk-wide enable pulse at 16× baud rate.
- rx_in  input  1  asynchronous serial line; idles high.
- data_out  output  WIDTH  last received word. Reset value 0.
- data_valid  output  1  one-clk pulse: good frame, data_out updated. Reset value 0.
- framing_err  output  1  one-clk pulse: stop bit sampled low. Reset value 0.
- parity_err  output  1  one-clk pulse: parity mismatch. Present only with the macro. Reset value 0.
- busy  output  1  high in every state except IDLE. Reset value 0.

## Operation
- Synchronizer:
  - rx_in passes through a 2-flop synchronizer; both flops reset to 1.
  - A third flop holds the previous synced value for falling-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP. Reset state is IDLE.
- IDLE:
  - On a synced falling edge (prev=1, cur=0), go to START.
  - On entry to START, clear the tick counter (4-bit) and bit counter (clog2(WIDTH) bits).
- START:
  - On the 8th tick (mid-bit), sample the line.
  - If 0, go to DATA and clear the tick counter.
  - If 1, this is a false start: return to IDLE with no outputs.
- DATA:
  - Every 16th tick, sample the line and shift it into the SIPO at the MSB, shifting right.
  - After WIDTH samples, go to PARITY if the macro is set, otherwise to STOP.
- PARITY:
  - On the 16th tick, sample the parity bit.
  - Expected value is XOR of the data bits, inverted when PARITY_ODD=1.
  - Latch the mismatch result, then go to STOP.
- STOP, on the 16th tick, sample the line:
  - Sample 1 and no parity mismatch: load data_out from the SIPO and pulse data_valid.
  - Sample 1 with parity mismatch: pulse parity_err; data_out unchanged; no data_valid.
  - Sample 0: pulse framing_err only; data_out unchanged; parity_err suppressed.
  - In all cases, go to IDLE.
- Counters and events:
  - Counters advance only on cycles where tick_16x=1; without ticks the FSM holds its state.
  - All events are evaluated on tick cycles only.
- Line held low after a framing error (break): no retrigger, because IDLE requires a 1→0 edge.
- data_valid, framing_err and parity_err are mutually exclusive.

## Timing
- Input latency: 2 clk through the synchronizer.
- Start detection: the edge is seen in the clk cycle after it reaches the synced output.
- Bit sampling:
  - Start bit is confirmed 8 ticks after detection.
  - Each later bit is sampled 16 ticks after the previous sample (bit centre).
- Output strobes:
  - data_valid, framing_err and parity_err assert on the clk after the stop-sample tick, for exactly one clk.
  - data_out is stable from that cycle until the next good frame.
- busy:
  - Rises the cycle after the start edge is detected.
  - Falls the same cycle the strobe asserts.
- Back-to-back frames: a start edge arriving one tick after the stop sample is accepted.
- rst asserted mid-frame: all state returns to reset values immediately, with no strobe. Reception resumes on the next falling edge after release.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is start + WIDTH data + parity + stop.
  - PARITY state and parity_err port exist.
- UART_RX_PARITY_EN undefined:
  - Frame is start + WIDTH data + stop.
  - No PARITY state, no parity_err port.
  - PARITY_ODD is ignored.

## Structure
- Shared package uart_pkg holds:
  - FSM state encoding constants (RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP).
  - OVERSAMPLE=16 and MID_SAMPLE=8 constants.
- Sub-module uart_sipo: WIDTH-bit serial-in/parallel-out register with shift enable and async active-low reset to 0. It mirrors the transmit shift register.

## Test plan
- Good frame: frame 0xA5 at 16 ticks/bit → data_out=0xA5; one-clk data_valid; busy low afterwards; no error strobes.
- Glitch rejection: rx_in low for 4 ticks, then high → no state beyond START; no strobes; busy returns low.
- Framing error: frame 0x3C with stop bit 0, line held low 3 bit-times → one framing_err pulse; data_out unchanged; no retrigger until the line goes high and falls again.
- Parity (UART_RX_PARITY_EN, PARITY_ODD=0):
  - Frame 0x07 with parity 1 → data_valid.
  - Frame 0x07 with parity 0 → parity_err; data_out keeps its old value.
- Back-to-back: frames 0x00 then 0xFF with no idle gap → two data_valid pulses; data_out 0x00, then 0xFF.
- Reset mid-frame: assert rst after 3 data bits of frame 0x5A → outputs at reset values; no strobe. After release, frame 0x81 → data_out=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver FSM state encoding
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

endpackage

// File: rtl/uart_sipo.sv
// rtl/uart_sipo.sv - serial-in/parallel-out register, bits enter at the MSB and shift right
module uart_sipo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (i_shift) begin
      r_data <= {i_bit, r_data[WIDTH-1:1]};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver; UART_RX_PARITY_EN adds a parity bit and parity_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_16x,
  input  logic             rx_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             framing_err,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             r_sync1, r_sync2, r_prev;
  rx_state_e        r_state, w_state_next;
  logic [3:0]       r_tick_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] w_sipo;
  logic             w_fall, w_mid, w_full, w_last_bit;
  logic             w_cnt_clr, w_shift, w_load, w_valid_next, w_ferr_next;

  // Synchronizer flops idle high so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall     = r_prev & ~r_sync2;
  assign w_mid      = tick_16x && (r_tick_cnt == 4'(MID_SAMPLE - 1));
  assign w_full     = tick_16x && (r_tick_cnt == 4'(OVERSAMPLE - 1));
  assign w_last_bit = (r_bit_cnt == BW'(WIDTH - 1));

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, w_par_latch, w_perr_next, w_par_exp;
  assign w_par_exp = (^w_sipo) ^ (PARITY_ODD != 0);
`else
  logic w_unused_odd;
  assign w_unused_odd = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RX_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_shift      = 1'b0;
    w_load       = 1'b0;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_latch  = 1'b0;
    w_perr_next  = 1'b0;
`endif
    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_state_next = RX_START;
          w_cnt_clr    = 1'b1;
        end
      end
      RX_START: begin
        if (w_mid) begin
          w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
          w_cnt_clr    = ~r_sync2;
        end
      end
      RX_DATA: begin
        if (w_full) begin
          w_shift = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (w_last_bit) w_state_next = RX_PARITY;
`else
          if (w_last_bit) w_state_next = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (w_full) begin
          w_par_latch  = 1'b1;
          w_state_next = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (w_full) begin
          w_state_next = RX_IDLE;
          // A low stop bit outranks a parity mismatch
          if (!r_sync2) begin
            w_ferr_next = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (r_par_bad) begin
            w_perr_next = 1'b1;
`endif
          end else begin
            w_valid_next = 1'b1;
            w_load       = 1'b1;
          end
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_cnt_clr) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (tick_16x && r_state != RX_IDLE) r_tick_cnt <= r_tick_cnt + 4'd1;
      if (w_shift) r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_par_bad <= 1'b0;
    else if (w_cnt_clr)   r_par_bad <= 1'b0;
    else if (w_par_latch) r_par_bad <= (r_sync2 != w_par_exp);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= w_perr_next;
  end
`endif

  uart_sipo #(.WIDTH(WIDTH)) u_sipo (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_shift),
    .i_bit   (r_sync2),
    .o_data  (w_sipo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      data_valid  <= w_valid_next;
      framing_err <= w_ferr_next;
      if (w_load) data_out <= w_sipo;
    end
  end

  assign busy = (r_state != RX_IDLE);

endmodule
